// File: rtl/ga20_sample_fetch.sv
// Sample-ROM line cache in front of the GA20 PCM block: serves byte reads from a small
// fully associative cache and fills misses with 64-bit line bursts over a req/ack port.
module ga20_sample_fetch #(
    parameter int unsigned LINES  = 4,
    parameter int unsigned ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_sample_rd,
    input  logic [ADDR_W-1:0] i_sample_addr,
    output logic              o_sample_valid,
    output logic [7:0]        o_sample_din,
    output logic              o_mem_req,
    output logic [ADDR_W-4:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [63:0]       i_mem_data
);

    localparam int unsigned IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned TAG_W = ADDR_W - 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_REPLAY
    } state_t;

    state_t            r_state;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag [LINES];
    logic [63:0]       r_data [LINES];
    logic [IDX_W-1:0]  r_victim;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              r_discard;
    logic              r_sample_valid;
    logic [7:0]        r_sample_din;
    logic              r_mem_req;
    logic [TAG_W-1:0]  r_mem_addr;

    logic [ADDR_W-1:0] w_lookup_addr;
    logic              w_hit;
    logic [IDX_W-1:0]  w_hit_idx;
    logic [7:0]        w_hit_byte;

    // REPLAY serves the newest strobe, including one arriving in the REPLAY cycle itself.
    always_comb begin
        w_lookup_addr = (r_state == ST_REPLAY && !i_sample_rd) ? r_pend_addr : i_sample_addr;
        w_hit         = 1'b0;
        w_hit_idx     = '0;
        for (int i = 0; i < LINES; i++) begin
            if (r_valid[i] && r_tag[i] == w_lookup_addr[ADDR_W-1:3]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
        w_hit_byte = r_data[w_hit_idx][{w_lookup_addr[2:0], 3'b000} +: 8];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_valid        <= '0;
            r_victim       <= '0;
            r_pend_addr    <= '0;
            r_discard      <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_din   <= 8'h00;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_sample_rd) begin
                r_pend_addr <= i_sample_addr;
            end
            if (i_flush) begin
                r_valid <= '0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (i_sample_rd) begin
                        if (w_hit && !i_flush) begin
                            r_sample_valid <= 1'b1;
                            r_sample_din   <= w_hit_byte;
                        end else begin
                            r_sample_valid <= 1'b0;
                            r_mem_req      <= 1'b1;
                            r_mem_addr     <= i_sample_addr[ADDR_W-1:3];
                            r_state        <= ST_FETCH;
                        end
                    end else if (i_flush) begin
                        r_sample_valid <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (i_sample_rd || i_flush) begin
                        r_sample_valid <= 1'b0;
                    end
                    if (i_flush) begin
                        r_discard <= 1'b1;
                    end
                    if (i_mem_ack) begin
                        // A flush seen at any point of the burst makes the returned line stale.
                        if (!r_discard && !i_flush) begin
                            r_valid[r_victim] <= 1'b1;
                            r_tag[r_victim]   <= r_mem_addr;
                            r_data[r_victim]  <= i_mem_data;
                            r_victim          <= r_victim + 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_discard <= 1'b0;
                        r_state   <= ST_REPLAY;
                    end
                end
                ST_REPLAY: begin
                    if (w_hit && !i_flush) begin
                        r_sample_valid <= 1'b1;
                        r_sample_din   <= w_hit_byte;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_sample_valid <= 1'b0;
                        r_mem_req      <= 1'b1;
                        r_mem_addr     <= w_lookup_addr[ADDR_W-1:3];
                        r_state        <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sample_valid = r_sample_valid;
    assign o_sample_din   = r_sample_din;
    assign o_mem_req      = r_mem_req;
    assign o_mem_addr     = r_mem_addr;

endmodule

// File: tb/tb_ga20_sample_fetch.sv
// Random and directed stimulus for ga20_sample_fetch, checked every cycle against a
// transaction-level cache model plus literal expectations for the directed scenarios.
module tb_ga20_sample_fetch;

    localparam int LINES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        rd = 1'b0;
    logic [19:0] addr = '0;
    logic        valid;
    logic [7:0]  din;
    logic        req;
    logic [16:0] maddr;
    logic        ack = 1'b0;
    logic [63:0] mdata = '0;

    int n_vec = 0;
    int n_err = 0;

    ga20_sample_fetch #(.LINES(LINES), .ADDR_W(20)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_flush        (flush),
        .i_sample_rd    (rd),
        .i_sample_addr  (addr),
        .o_sample_valid (valid),
        .o_sample_din   (din),
        .o_mem_req      (req),
        .o_mem_addr     (maddr),
        .i_mem_ack      (ack),
        .i_mem_data     (mdata)
    );

    always #5 clk = ~clk;

    // Behavioural model: cache contents, one outstanding line fetch, a pending replay.
    logic        m_v   [LINES];
    logic [16:0] m_tag [LINES];
    logic [63:0] m_dat [LINES];
    int          m_victim;
    logic [19:0] m_pend;
    logic        m_req, m_discard, m_replay, m_sv;
    logic [7:0]  m_din;
    logic [16:0] m_maddr;

    function automatic logic [63:0] rom(input logic [16:0] l);
        return {l, 15'h1234 ^ l[14:0], l ^ 17'h1abcd, 15'h3ff ^ {l[6:0], l[16:9]}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_dat[i] = '0;
        end
        m_victim = 0; m_pend = '0; m_req = 0; m_discard = 0; m_replay = 0;
        m_sv = 0; m_din = 8'h00; m_maddr = '0;
    endtask

    task automatic model_step();
        logic [19:0] la;
        logic        hit;
        logic [7:0]  b;
        if (m_req) begin
            if (rd || flush) m_sv = 0;
            if (flush) for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
            if (ack) begin
                if (!m_discard && !flush) begin
                    m_v[m_victim] = 1'b1;
                    m_tag[m_victim] = m_maddr;
                    m_dat[m_victim] = mdata;
                    m_victim = (m_victim + 1) % LINES;
                end
                m_req = 0; m_discard = 0; m_replay = 1;
            end else if (flush) begin
                m_discard = 1;
            end
        end else begin
            la = rd ? addr : m_pend;
            if (rd || m_replay) begin
                hit = 0; b = 8'h00;
                for (int i = 0; i < LINES; i++) begin
                    if (m_v[i] && m_tag[i] == la[19:3]) begin
                        logic [63:0] w;
                        w = m_dat[i] >> (8 * int'(la[2:0]));
                        hit = 1; b = w[7:0];
                    end
                end
                if (hit && !flush) begin
                    m_sv = 1; m_din = b;
                end else begin
                    m_sv = 0; m_req = 1; m_maddr = la[19:3];
                end
                m_replay = 0;
            end else if (flush) begin
                m_sv = 0;
            end
            if (flush) for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
        end
        if (rd) m_pend = addr;
    endtask

    task automatic compare_all();
        chk("cyc_valid", 64'(valid), 64'(m_sv));
        chk("cyc_din", 64'(din), 64'(m_din));
        chk("cyc_req", 64'(req), 64'(m_req));
        chk("cyc_maddr", 64'(maddr), 64'(m_maddr));
    endtask

    // One clock: model advances on the edge, outputs compared 1 ns later, return at negedge.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [19:0] a);
        rd = 1; addr = a; cyc(); rd = 0;
        for (int i = 0; i < 8 && !req; i++) cyc();
        chk("fetch_req", 64'(req), 64'd1);
        ack = 1; mdata = rom(maddr); cyc(); ack = 0;
        for (int i = 0; i < 8 && !valid; i++) cyc();
        chk("fetch_valid", 64'(valid), 64'd1);
    endtask

    initial begin
        logic [63:0] d;
        int          wcnt;
        logic [16:0] ln;

        model_reset();
        #1;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_din", 64'(din), 64'h00);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_maddr", 64'(maddr), 64'd0);
        @(negedge clk);
        cyc(); cyc();
        rst_n = 1;
        cyc();

        // 1: cold miss
        rd = 1; addr = 20'h01234; cyc(); rd = 0;
        chk("t1_req", 64'(req), 64'd1);
        chk("t1_maddr", 64'(maddr), 64'h0246);
        ack = 1; mdata = 64'h8877665544332211; cyc(); ack = 0;
        chk("t1_valid_early", 64'(valid), 64'd0);
        cyc();
        chk("t1_valid", 64'(valid), 64'd1);
        chk("t1_din", 64'(din), 64'h55);

        // 2: hit, one clock latency
        rd = 1; addr = 20'h01237; cyc(); rd = 0;
        chk("t2_valid", 64'(valid), 64'd1);
        chk("t2_din", 64'(din), 64'h88);
        chk("t2_req", 64'(req), 64'd0);

        // 3: re-strobe during FETCH
        rd = 1; addr = 20'h00010; cyc();
        chk("t3_req", 64'(req), 64'd1);
        chk("t3_maddr", 64'(maddr), 64'h0002);
        addr = 20'h01230; cyc(); rd = 0;
        chk("t3_maddr_frozen", 64'(maddr), 64'h0002);
        ack = 1; mdata = rom(17'h0002); cyc(); ack = 0;
        cyc();
        chk("t3_valid", 64'(valid), 64'd1);
        chk("t3_din", 64'(din), 64'h11);
        chk("t3_req_low", 64'(req), 64'd0);

        // 4: round-robin eviction of the oldest line
        fetch(20'h00800);
        fetch(20'h00808);
        fetch(20'h00810);
        rd = 1; addr = 20'h00010; cyc(); rd = 0;
        d = rom(17'h0002);
        chk("t4_hit_valid", 64'(valid), 64'd1);
        chk("t4_hit_din", 64'(din), 64'(d[7:0]));
        rd = 1; addr = 20'h01234; cyc(); rd = 0;
        chk("t4_evicted_req", 64'(req), 64'd1);
        chk("t4_evicted_maddr", 64'(maddr), 64'h0246);
        ack = 1; mdata = 64'h8877665544332211; cyc(); ack = 0;
        cyc();
        chk("t4_refill_din", 64'(din), 64'h55);

        // 5: flush during FETCH discards the fill
        rd = 1; addr = 20'h05000; cyc(); rd = 0;
        chk("t5_req", 64'(req), 64'd1);
        chk("t5_maddr", 64'(maddr), 64'h0a00);
        flush = 1; cyc(); flush = 0;
        ack = 1; mdata = 64'hdeadbeefcafef00d; cyc(); ack = 0;
        cyc();
        chk("t5_refetch_req", 64'(req), 64'd1);
        chk("t5_refetch_maddr", 64'(maddr), 64'h0a00);
        chk("t5_no_valid", 64'(valid), 64'd0);
        ack = 1; mdata = 64'h0102030405060708; cyc(); ack = 0;
        cyc();
        chk("t5_valid", 64'(valid), 64'd1);
        chk("t5_din", 64'(din), 64'h08);

        // 6: reset while mem_req is high, then a stray ack
        rd = 1; addr = 20'h07008; cyc(); rd = 0;
        chk("t6_req", 64'(req), 64'd1);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("t6_rst_req", 64'(req), 64'd0);
        chk("t6_rst_valid", 64'(valid), 64'd0);
        chk("t6_rst_din", 64'(din), 64'h00);
        @(negedge clk);
        cyc();
        rst_n = 1;
        ack = 1; mdata = 64'h1111111111111111; cyc(); ack = 0;
        chk("t6_stray_req", 64'(req), 64'd0);
        chk("t6_stray_valid", 64'(valid), 64'd0);
        rd = 1; addr = 20'h01234; cyc(); rd = 0;
        chk("t6_cold_req", 64'(req), 64'd1);
        ack = 1; mdata = 64'h8877665544332211; cyc(); ack = 0;
        cyc();
        chk("t6_din", 64'(din), 64'h55);

        // Random traffic with a lagging memory responder
        wcnt = 0;
        for (int n = 0; n < 4000; n++) begin
            rd = ($urandom_range(0, 99) < 40);
            ln = 17'($urandom_range(0, 9) * 37) + 17'h1fff0;
            addr = ($urandom_range(0, 19) == 0) ? 20'($urandom) : {ln, 3'($urandom)};
            flush = ($urandom_range(0, 99) < 3);
            ack = 0;
            if (req) begin
                if (wcnt == 0) begin
                    ack = 1; mdata = rom(maddr); wcnt = $urandom_range(0, 3);
                end else begin
                    wcnt--;
                end
            end else if ($urandom_range(0, 49) == 0) begin
                ack = 1; mdata = {$urandom, $urandom};
            end
            cyc();
        end
        rd = 0; flush = 0; ack = 0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
